// File: rtl/soc_system_pll_reconfig_seq.sv
// PLL reconfiguration sequencer: writes mode/N/M/K/C settings over the mgmt port,
// starts reconfiguration, polls status, then waits for PLL lock.
module soc_system_pll_reconfig_seq #(
   parameter int unsigned NUM_CLOCKS     = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                         refclk,
   input  logic                         rst,
   input  logic                         cfg_valid,
   output logic                         cfg_ready,
   input  logic [17:0]                  cfg_n,
   input  logic [17:0]                  cfg_m,
   input  logic [31:0]                  cfg_k,
   input  logic [18*NUM_CLOCKS-1:0]     cfg_c,
   input  logic [NUM_CLOCKS-1:0]        cfg_c_en,
   output logic [5:0]                   mgmt_address,
   output logic                         mgmt_write,
   output logic                         mgmt_read,
   output logic [31:0]                  mgmt_writedata,
   input  logic [31:0]                  mgmt_readdata,
   input  logic                         mgmt_waitrequest,
   input  logic                         pll_locked,
   output logic                         busy,
   output logic                         done,
   output logic                         error,
   output logic [1:0]                   err_code
);

   localparam int unsigned CW = 18;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_MODE  = 4'd1;
   localparam logic [3:0] S_WR_N  = 4'd2;
   localparam logic [3:0] S_WR_M  = 4'd3;
   localparam logic [3:0] S_WR_K  = 4'd4;
   localparam logic [3:0] S_WR_C  = 4'd5;
   localparam logic [3:0] S_START = 4'd6;
   localparam logic [3:0] S_POLL  = 4'd7;
   localparam logic [3:0] S_LOCK  = 4'd8;

   logic [3:0]               state, nxt_state;
   logic [NUM_CLOCKS-1:0]    c_pend, nxt_pend;
   logic [17:0]              n_q, m_q;
   logic [31:0]              k_q;
   logic [CW*NUM_CLOCKS-1:0] c_q;
   logic [TW-1:0]            cnt, nxt_cnt;
   logic                     lock_meta, lock_sync;

   logic                     accept, acc_done, cnt_hit;
   logic                     nxt_done, nxt_err;
   logic [1:0]               nxt_code;
   logic [5:0]               nxt_addr;
   logic                     nxt_wr, nxt_rd;
   logic [31:0]              nxt_wdata;
   logic [4:0]               c_idx;
   logic                     unused_c;

   assign unused_c = ^mgmt_readdata[31:1];

   // Lowest pending C counter index; counters are programmed in ascending order.
   function automatic logic [4:0] low_idx(input logic [NUM_CLOCKS-1:0] mask);
      low_idx = '0;
      for (int i = int'(NUM_CLOCKS) - 1; i >= 0; i--) begin
         if (mask[i]) low_idx = 5'(i);
      end
   endfunction

   // Next-state and next registered-output logic
   always_comb begin
      nxt_state = state;
      nxt_pend  = c_pend;
      accept    = 1'b0;
      nxt_done  = 1'b0;
      nxt_err   = error;
      nxt_code  = err_code;
      acc_done  = (mgmt_write | mgmt_read) & ~mgmt_waitrequest;
      cnt_hit   = (cnt == TW'(TIMEOUT_CYCLES - 1));
      nxt_addr  = '0;
      nxt_wr    = 1'b0;
      nxt_rd    = 1'b0;
      nxt_wdata = '0;
      c_idx     = '0;

      case (state)
         S_IDLE: begin
            if (cfg_valid && cfg_ready) begin
               accept    = 1'b1;
               nxt_state = S_MODE;
               nxt_err   = 1'b0;
               nxt_code  = 2'd0;
               nxt_pend  = cfg_c_en;
            end
         end
         S_MODE:  if (acc_done) nxt_state = S_WR_N;
         S_WR_N:  if (acc_done) nxt_state = S_WR_M;
         S_WR_M:  if (acc_done) nxt_state = S_WR_K;
         S_WR_K:  if (acc_done) nxt_state = (|c_pend) ? S_WR_C : S_START;
         S_WR_C: begin
            if (acc_done) begin
               nxt_pend = c_pend & (c_pend - NUM_CLOCKS'(1));
               if (nxt_pend == '0) nxt_state = S_START;
            end
         end
         S_START: if (acc_done) nxt_state = S_POLL;
         S_POLL: begin
            if (acc_done && mgmt_readdata[0]) begin
               nxt_state = S_LOCK;
            end else if (cnt_hit) begin
               nxt_state = S_IDLE;
               nxt_err   = 1'b1;
               nxt_code  = 2'd1;
            end
         end
         S_LOCK: begin
            if (lock_sync) begin
               nxt_state = S_IDLE;
               nxt_done  = 1'b1;
            end else if (cnt_hit) begin
               nxt_state = S_IDLE;
               nxt_err   = 1'b1;
               nxt_code  = 2'd2;
            end
         end
         default: nxt_state = S_IDLE;
      endcase

      case (nxt_state)
         S_MODE:  begin nxt_addr = 6'h00; nxt_wr = 1'b1; nxt_wdata = 32'd1; end
         S_WR_N:  begin nxt_addr = 6'h03; nxt_wr = 1'b1; nxt_wdata = {14'b0, n_q}; end
         S_WR_M:  begin nxt_addr = 6'h04; nxt_wr = 1'b1; nxt_wdata = {14'b0, m_q}; end
         S_WR_K:  begin nxt_addr = 6'h07; nxt_wr = 1'b1; nxt_wdata = k_q; end
         S_WR_C: begin
            c_idx     = low_idx(nxt_pend);
            nxt_addr  = 6'h05;
            nxt_wr    = 1'b1;
            nxt_wdata = {9'b0, c_idx, c_q[int'(c_idx)*CW +: CW]};
         end
         S_START: begin nxt_addr = 6'h02; nxt_wr = 1'b1; nxt_wdata = 32'd0; end
         S_POLL:  begin nxt_addr = 6'h01; nxt_rd = 1'b1; end
         default: ;
      endcase

      // Timeout only advances while dwelling in POLL or LOCK
      if ((state == S_POLL && nxt_state == S_POLL) || (state == S_LOCK && nxt_state == S_LOCK))
         nxt_cnt = cnt + TW'(1);
      else
         nxt_cnt = '0;
   end

   // State and registered outputs
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         c_pend         <= '0;
         n_q            <= '0;
         m_q            <= '0;
         k_q            <= '0;
         c_q            <= '0;
         cnt            <= '0;
         lock_meta      <= 1'b0;
         lock_sync      <= 1'b0;
         cfg_ready      <= 1'b1;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
         err_code       <= 2'd0;
         mgmt_address   <= '0;
         mgmt_write     <= 1'b0;
         mgmt_read      <= 1'b0;
         mgmt_writedata <= '0;
      end else begin
         state          <= nxt_state;
         c_pend         <= nxt_pend;
         cnt            <= nxt_cnt;
         lock_meta      <= pll_locked;
         lock_sync      <= lock_meta;
         cfg_ready      <= (nxt_state == S_IDLE);
         busy           <= (nxt_state != S_IDLE);
         done           <= nxt_done;
         error          <= nxt_err;
         err_code       <= nxt_code;
         mgmt_address   <= nxt_addr;
         mgmt_write     <= nxt_wr;
         mgmt_read      <= nxt_rd;
         mgmt_writedata <= nxt_wdata;
         if (accept) begin
            n_q <= cfg_n;
            m_q <= cfg_m;
            k_q <= cfg_k;
            c_q <= cfg_c;
         end
      end
   end

endmodule
